mod_n_up_counter: RTL
=====================

Name: mod_n_up_counter

Overview:
- Cascadable modulo-N binary up counter. It is the incrementing counterpart to the team's N-bit down counter and shares the same MOD_VALUE parameterisation and output sizing.
- Counts 0 -> MOD_VALUE-1 and then wraps to 0.
- Supports enable, carry chaining, synchronous clear and parallel load, a one-shot stop mode, and wrap event reporting.
- Used for timebases, BCD digit chains and event dividers.

Parameters:
- MOD_VALUE, 8, counter modulus; legal values >= 2. W = $clog2(MOD_VALUE).
- ONE_SHOT, 0, 0 = free-running wrap; 1 = halt at MOD_VALUE-1 until clear or load.
- WRAP_W, 8, width of the saturating wrap-event counter.

Ports:
- clk  input  1  rising-edge clock.
- rstn  input  1  asynchronous active-low reset.
- en  input  1  count enable.
- cin  input  1  carry in; counting requires en & cin. Tie to 1 when not cascaded.
- clr  input  1  synchronous clear.
- load  input  1  synchronous parallel load.
- load_val  input  W  value to load.
- out  output  W  current count.
- cout  output  1  combinational carry out: (out == MOD_VALUE-1) & en & cin & ~clr & ~load & ~halted.
- wrap_pulse  output  1  registered; high for one cycle after each wrap MOD_VALUE-1 -> 0.
- halted  output  1  high while ONE_SHOT=1 and the counter is frozen at MOD_VALUE-1.
- load_err  output  1  registered; high for one cycle after an out-of-range load.
- wrap_cnt  output  WRAP_W  number of wraps since reset or clear; saturates at all-ones.

Behaviour:
- Reset (rstn=0, asynchronous): out=0, wrap_pulse=0, halted=0, load_err=0, wrap_cnt=0. Outputs hold these values while rstn is low. First update occurs at the first posedge after release.
- Each posedge, in priority order (exactly one action applies):
  1. clr=1: out=0, halted=0, wrap_cnt=0, wrap_pulse=0, load_err=0.
  2. load=1:
     - If load_val <= MOD_VALUE-1: out=load_val, load_err=0.
     - Otherwise: out=0, load_err=1 for one cycle.
     - In both cases halted=0 and wrap_cnt is unchanged.
  3. step = en & cin & ~halted:
     - If out < MOD_VALUE-1: out=out+1.
     - If out == MOD_VALUE-1 and ONE_SHOT=0: out=0, wrap_pulse=1, wrap_cnt=wrap_cnt+1 (saturating).
     - If out == MOD_VALUE-1 and ONE_SHOT=1: out holds, halted=1, wrap_pulse=0, wrap_cnt unchanged.
  4. Otherwise: out holds.
- wrap_pulse and load_err default to 0 every cycle unless set above.
- Latency:
  - out changes one cycle after a qualifying edge.
  - cout is same-cycle combinational, so a chained stage advances on the same edge the lower stage wraps.
- Arithmetic: out never exceeds MOD_VALUE-1, including for non-power-of-two MOD_VALUE. The wrap target is always 0, never all-ones.
- ONE_SHOT=1 behaviour:
  - out reaches MOD_VALUE-1 on the step that makes it so.
  - The next qualifying step sets halted. cout is high in that cycle and low afterwards.
  - Only clr, load or reset leave the halted state.
- Simultaneous events:
  - clr overrides load and step.
  - load overrides step; no wrap is reported even if out == MOD_VALUE-1.
- en=1 with cin=0: no change.
- Reset asserted mid-count: immediate return to reset values regardless of clk.

Test Plan:
- MOD_VALUE=10, ONE_SHOT=0, en=cin=1 for 25 cycles from reset -> out sequence 0..9,0..9,0..4. wrap_pulse high exactly 2 cycles (each cycle out==0 after 9). wrap_cnt=2. cout high in cycles where out==9.
- MOD_VALUE=10, load=1 load_val=7 then counting -> out 7,8,9,0. load_val=12 -> out=0 and load_err=1 for one cycle.
- Two instances chained (lower cout -> upper cin), MOD_VALUE=10 each, 100 enabled cycles -> upper:lower steps through 00..99 and returns to 00. Upper wrap_pulse fires once.
- ONE_SHOT=1, MOD_VALUE=5, en=cin=1 -> out 0,1,2,3,4 then holds 4, halted=1, cout low. clr -> out=0, halted=0.
- At out=9 with en=cin=1, assert clr and load (load_val=3) together -> out=0, wrap_pulse=0, wrap_cnt=0. At out=9, load=1 alone with load_val=3 -> out=3, no wrap_pulse.
- Drop rstn asynchronously mid-cycle at out=6 -> out=0 and all flags 0 before the next clk edge. Counting resumes from 0 after release. WRAP_W=2, 5 wraps -> wrap_cnt saturates at 3.

Source files
------------

// File: rtl/mod_n_up_counter.sv
// Cascadable modulo-N up counter with carry chaining, clear/load, one-shot halt,
// wrap pulse and a saturating wrap-event counter.
module mod_n_up_counter #(
   parameter int unsigned MOD_VALUE = 8,
   parameter int unsigned ONE_SHOT  = 0,
   parameter int unsigned WRAP_W    = 8,
   localparam int unsigned W        = $clog2(MOD_VALUE)
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              en,
   input  logic              cin,
   input  logic              clr,
   input  logic              load,
   input  logic [W-1:0]      load_val,
   output logic [W-1:0]      out,
   output logic              cout,
   output logic              wrap_pulse,
   output logic              halted,
   output logic              load_err,
   output logic [WRAP_W-1:0] wrap_cnt
);

   localparam logic [W-1:0] MAX = W'(MOD_VALUE - 1);

   logic              at_max;
   logic              step;
   logic [W-1:0]      nxt_out;
   logic              nxt_halted;
   logic              nxt_wrap_pulse;
   logic              nxt_load_err;
   logic [WRAP_W-1:0] nxt_wrap_cnt;

   assign at_max = (out == MAX);
   assign step   = en & cin & ~halted;
   assign cout   = at_max & en & cin & ~clr & ~load & ~halted;

   always_comb begin
      nxt_out        = out;
      nxt_halted     = halted;
      nxt_wrap_pulse = 1'b0;
      nxt_load_err   = 1'b0;
      nxt_wrap_cnt   = wrap_cnt;
      if (clr) begin
         nxt_out      = '0;
         nxt_halted   = 1'b0;
         nxt_wrap_cnt = '0;
      end else if (load) begin
         nxt_halted = 1'b0;
         if (load_val <= MAX) begin
            nxt_out = load_val;
         end else begin
            nxt_out      = '0;
            nxt_load_err = 1'b1;
         end
      end else if (step) begin
         if (!at_max) begin
            nxt_out = out + 1'b1;
         end else if (ONE_SHOT != 0) begin
            // Freeze at terminal count; no wrap is reported in one-shot mode.
            nxt_halted = 1'b1;
         end else begin
            nxt_out        = '0;
            nxt_wrap_pulse = 1'b1;
            if (wrap_cnt != '1) nxt_wrap_cnt = wrap_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out        <= '0;
         halted     <= 1'b0;
         wrap_pulse <= 1'b0;
         load_err   <= 1'b0;
         wrap_cnt   <= '0;
      end else begin
         out        <= nxt_out;
         halted     <= nxt_halted;
         wrap_pulse <= nxt_wrap_pulse;
         load_err   <= nxt_load_err;
         wrap_cnt   <= nxt_wrap_cnt;
      end
   end

endmodule
